// File: rtl/gpc23_weighted_popcount_seq_if.sv
// rtl/gpc23_weighted_popcount_seq_if.sv - operand/result handshake bundle for the weighted popcount sequencer
interface gpc23_weighted_popcount_seq_if #(
    parameter int WA = 12,
    parameter int WB = 8
);
    localparam int SUM_W = $clog2(WA + 2 * WB + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WA-1:0]    in_a;
    logic [WB-1:0]    in_b;
    logic             out_valid;
    logic             out_ready;
    logic [SUM_W-1:0] out_sum;
    logic             busy;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_sum, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_sum, busy
    );
endinterface

// File: rtl/gpc23_weighted_popcount_seq.sv
// rtl/gpc23_weighted_popcount_seq.sv - popcount(a)+2*popcount(b) by time-sharing one (2,3;3) GPC
module gpc23_3 (
    input  logic [2:0] src0,
    input  logic [1:0] src1,
    output logic [2:0] dst
);
    always_comb begin
        dst = 3'(src0[0]) + 3'(src0[1]) + 3'(src0[2])
            + {1'b0, src1[0], 1'b0} + {1'b0, src1[1], 1'b0};
    end
endmodule

module gpc23_weighted_popcount_seq #(
    parameter int WA = 12,
    parameter int WB = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    gpc23_weighted_popcount_seq_if.slave  bus
);
    localparam int NA     = (WA + 2) / 3;
    localparam int NB     = (WB + 1) / 2;
    localparam int NSTEP  = (NA > NB) ? NA : NB;
    localparam int PA     = 3 * NSTEP;
    localparam int PB     = 2 * NSTEP;
    localparam int SUM_W  = $clog2(WA + 2 * WB + 1);
    localparam int STEP_W = $clog2(NSTEP + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [PA-1:0]     sh_a;
    logic [PB-1:0]     sh_b;
    logic [SUM_W-1:0]  acc;
    logic [SUM_W-1:0]  sum_next;
    logic [SUM_W-1:0]  out_sum_r;
    logic [STEP_W-1:0] step;
    logic [2:0]        dst;
    logic              last_step;

    // Operands shift right by one chunk per step, so the GPC always sees the low bits;
    // zero padding above the operand widths makes exhausted chunks contribute nothing.
    gpc23_3 u_gpc (
        .src0 (sh_a[2:0]),
        .src1 (sh_b[1:0]),
        .dst  (dst)
    );

    assign sum_next  = acc + SUM_W'(dst);
    assign last_step = (step == STEP_W'(NSTEP - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (bus.in_valid) state_next = RUN;
            RUN:  if (last_step) state_next = DONE;
            DONE: if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_a      <= '0;
            sh_b      <= '0;
            acc       <= '0;
            step      <= '0;
            out_sum_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        sh_a <= PA'(bus.in_a);
                        sh_b <= PB'(bus.in_b);
                        acc  <= '0;
                        step <= '0;
                    end
                end
                RUN: begin
                    acc  <= sum_next;
                    sh_a <= sh_a >> 3;
                    sh_b <= sh_b >> 2;
                    step <= step + 1'b1;
                    if (last_step) begin
                        out_sum_r <= sum_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Acceptance only in IDLE keeps DONE and the next operation from overlapping.
    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.out_sum   = out_sum_r;
endmodule

// File: tb/tb_gpc23_weighted_popcount_seq.sv
// tb/tb_gpc23_weighted_popcount_seq.sv - scoreboard bench for the weighted popcount sequencer
module tb_gpc23_weighted_popcount_seq;
    logic clk;
    logic rst;
    logic cur;
    int   tests;
    int   fails;
    logic [4:0] sb[$];

    gpc23_weighted_popcount_seq_if #(.WA(12), .WB(8)) bus0 ();
    gpc23_weighted_popcount_seq_if #(.WA(5),  .WB(1)) bus1 ();

    gpc23_weighted_popcount_seq #(.WA(12), .WB(8)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    gpc23_weighted_popcount_seq #(.WA(5),  .WB(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    wire       mv = cur ? bus1.out_valid : bus0.out_valid;
    wire       mr = cur ? bus1.in_ready  : bus0.in_ready;
    wire       mb = cur ? bus1.busy      : bus0.busy;
    wire [4:0] ms = cur ? {2'b00, bus1.out_sum} : bus0.out_sum;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [11:0] a, input logic [7:0] b);
        if (cur) begin
            bus1.in_valid = v;
            bus1.in_a     = a[4:0];
            bus1.in_b     = b[0];
        end else begin
            bus0.in_valid = v;
            bus0.in_a     = a;
            bus0.in_b     = b;
        end
    endtask

    task automatic set_ordy(input logic r);
        if (cur) bus1.out_ready = r;
        else     bus0.out_ready = r;
    endtask

    function automatic logic [4:0] model(input logic [11:0] a, input logic [7:0] b);
        if (cur) return 5'($countones(a[4:0]) + 2 * int'(b[0]));
        return 5'($countones(a) + 2 * $countones(b));
    endfunction

    task automatic wait_ready();
        int n;
        n = 0;
        while (!mr && n < 20) begin
            tick();
            n++;
        end
        check("in_ready_wait", 32'(mr), 32'd1);
    endtask

    task automatic wait_result(input string tag);
        int lat;
        int rdy_seen;
        logic [4:0] exp;
        lat = 0;
        rdy_seen = 0;
        while (!mv && lat < 20) begin
            if (mr) rdy_seen++;
            tick();
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), cur ? 32'd2 : 32'd4);
        check({tag, "_ready_in_run"}, 32'(rdy_seen), 32'd0);
        exp = (sb.size() > 0) ? sb.pop_front() : 5'h1f;
        check({tag, "_sum"}, 32'(ms), 32'(exp));
    endtask

    task automatic do_op(input string tag, input logic [11:0] a, input logic [7:0] b, input int hold);
        logic [4:0] held;
        wait_ready();
        drive(1'b1, a, b);
        sb.push_back(model(a, b));
        tick();
        drive(1'b0, 12'h000, 8'h00);
        wait_result(tag);
        held = ms;
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, "_held_sum"}, 32'(ms), 32'(held));
            check({tag, "_held_ready"}, 32'(mr), 32'd0);
        end
        set_ordy(1'b1);
        tick();
        set_ordy(1'b0);
        check({tag, "_valid_drop"}, 32'(mv), 32'd0);
        check({tag, "_idle_ready"}, 32'(mr), 32'd1);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        cur   = 1'b0;
        rst   = 1'b1;
        bus0.in_valid = 1'b0; bus0.in_a = '0; bus0.in_b = '0; bus0.out_ready = 1'b0;
        bus1.in_valid = 1'b0; bus1.in_a = '0; bus1.in_b = '0; bus1.out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        check("rst_in_ready", 32'(bus0.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus0.out_valid), 32'd0);
        check("rst_out_sum", 32'(bus0.out_sum), 32'd0);
        check("rst_busy", 32'(bus0.busy), 32'd0);
        check("rst1_in_ready", 32'(bus1.in_ready), 32'd1);
        check("rst1_out_valid", 32'(bus1.out_valid), 32'd0);

        // T1..T3 directed on the default geometry
        do_op("t1_all_ones", 12'hFFF, 8'hFF, 0);
        check("t1_const", 32'(model(12'hFFF, 8'hFF)), 32'd28);
        do_op("t2_zero", 12'h000, 8'h00, 1);
        do_op("t3_a", 12'h005, 8'h01, 0);
        do_op("t3_b", 12'h924, 8'hAA, 2);

        // T4: stall in DONE while a second operand is already offered
        wait_ready();
        drive(1'b1, 12'h0F0, 8'h03);
        sb.push_back(model(12'h0F0, 8'h03));
        tick();
        drive(1'b1, 12'h00F, 8'h0F);
        wait_result("t4_first");
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t4_held_sum", 32'(ms), 32'd8);
            check("t4_held_valid", 32'(mv), 32'd1);
            check("t4_no_accept", 32'(mr), 32'd0);
        end
        set_ordy(1'b1);
        tick();
        set_ordy(1'b0);
        check("t4_idle_ready", 32'(mr), 32'd1);
        check("t4_valid_drop", 32'(mv), 32'd0);
        sb.push_back(model(12'h00F, 8'h0F));
        tick();
        drive(1'b0, 12'h000, 8'h00);
        wait_result("t4_second");
        set_ordy(1'b1);
        tick();
        set_ordy(1'b0);

        // T5: reset on the second RUN cycle discards the operation
        wait_ready();
        drive(1'b1, 12'hFFF, 8'hFF);
        tick();
        drive(1'b0, 12'h000, 8'h00);
        tick();
        check("t5_busy_before", 32'(mb), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_in_ready", 32'(mr), 32'd1);
        check("t5_out_valid", 32'(mv), 32'd0);
        check("t5_out_sum", 32'(ms), 32'd0);
        check("t5_busy", 32'(mb), 32'd0);
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 8; i++) begin
                tick();
                if (mv) seen++;
            end
            check("t5_no_pulse", 32'(seen), 32'd0);
        end

        for (int i = 0; i < 20; i++) begin
            do_op("rand_w12", 12'($urandom_range(0, 4095)), 8'($urandom_range(0, 255)),
                  int'($urandom_range(0, 2)));
        end

        // T6: narrow geometry, NSTEP=2
        cur = 1'b1;
        do_op("t6_directed", 12'h01F, 8'h01, 0);
        check("t6_const", 32'(model(12'h01F, 8'h01)), 32'd7);
        for (int i = 0; i < 200; i++) begin
            do_op("t6_rand", 12'($urandom_range(0, 31)), 8'($urandom_range(0, 1)),
                  int'($urandom_range(0, 1)));
        end
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
